// File: rtl/red_reduce_seq.sv
// Sequential AND/OR/XOR reduction of a word, chunk bits per cycle, with
// optional early termination for AND/OR and a valid/ready handshake on each side.
`timescale 1ns/1ps
module red_reduce_seq #(
    parameter int unsigned width      = 32,
    parameter int unsigned chunk      = 8,
    parameter bit          early_exit = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [width-1:0] A,
    input  logic [1:0]       Op,
    input  logic             InValid,
    output logic             InReady,
    output logic             Z,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Busy
);

    localparam int unsigned csz    = (chunk > width) ? width : chunk;
    localparam int unsigned nbeats = (width + csz - 1) / csz;
    localparam int unsigned cw     = (nbeats > 1) ? $clog2(nbeats) : 1;
    localparam int unsigned pw     = nbeats * csz;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [width-1:0] a_r;
    logic [1:0]       op_r;
    logic             acc;
    logic [cw-1:0]    cnt;

    logic             is_and, is_or, is_xor;
    logic [pw-1:0]    padded;
    logic [csz-1:0]   beat;
    logic             beat_red, acc_nx, last, early, finish, accept, in_ident;

    // Datapath: select current chunk from the identity-padded operand and fold it in.
    always_comb begin
        is_or  = (op_r == 2'b01);
        is_xor = (op_r == 2'b10);
        is_and = !is_or && !is_xor;

        padded              = is_and ? '1 : '0;
        padded[width-1:0]   = a_r;

        beat = '0;
        for (int unsigned k = 0; k < nbeats; k++) begin
            if (cnt == cw'(k)) beat = padded[k*csz +: csz];
        end

        beat_red = is_and ? (&beat) : (is_or ? (|beat) : (^beat));
        acc_nx   = is_and ? (acc & beat_red) : (is_or ? (acc | beat_red) : (acc ^ beat_red));
        last     = (cnt == cw'(nbeats - 1));
        early    = early_exit && ((is_and && !beat_red) || (is_or && beat_red));
        finish   = last || early;

        in_ident = !((Op == 2'b01) || (Op == 2'b10));
    end

    always_comb begin
        state_nx = state;
        InReady  = (state == IDLE) && rst_ni;
        OutValid = (state == DONE);
        Busy     = (state != IDLE);
        accept   = InValid && InReady;
        case (state)
            IDLE: if (accept)   state_nx = RUN;
            RUN:  if (finish)   state_nx = DONE;
            DONE: if (OutReady) state_nx = IDLE;
            default:            state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_r  <= '0;
            op_r <= '0;
            acc  <= 1'b0;
            cnt  <= '0;
            Z    <= 1'b0;
        end else if (accept) begin
            a_r  <= A;
            op_r <= Op;
            acc  <= in_ident;
            cnt  <= '0;
        end else if (state == RUN) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (finish) Z <= acc_nx;
        end
    end

endmodule

// File: tb/tb_red_reduce_seq.sv
// Directed bench for red_reduce_seq: three instances (32/8 early, 32/8 no early, 10/4 early)
// share the input side; each scenario task checks results and latencies against hand values.
`timescale 1ns/1ps
module tb_red_reduce_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_in;
    logic [1:0]  op_in;
    logic        in_valid, out_ready;
    logic [2:0]  rdy, zo, ov, busy;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int          lat [3];
    logic        zr  [3];

    always #5 clk = ~clk;

    red_reduce_seq #(.width(32), .chunk(8), .early_exit(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .A(a_in), .Op(op_in), .InValid(in_valid),
        .InReady(rdy[0]), .Z(zo[0]), .OutValid(ov[0]), .OutReady(out_ready), .Busy(busy[0]));

    red_reduce_seq #(.width(32), .chunk(8), .early_exit(1'b0)) dut_ne (
        .clk_i(clk), .rst_ni(rst_n), .A(a_in), .Op(op_in), .InValid(in_valid),
        .InReady(rdy[1]), .Z(zo[1]), .OutValid(ov[1]), .OutReady(out_ready), .Busy(busy[1]));

    red_reduce_seq #(.width(10), .chunk(4), .early_exit(1'b1)) dut_w10 (
        .clk_i(clk), .rst_ni(rst_n), .A(a_in[9:0]), .Op(op_in), .InValid(in_valid),
        .InReady(rdy[2]), .Z(zo[2]), .OutValid(ov[2]), .OutReady(out_ready), .Busy(busy[2]));

    // One transaction on all instances; lat[i] = cycles from accept to first OutValid.
    task automatic run_op(input logic [31:0] a, input logic [1:0] op);
        @(negedge clk);
        a_in = a; op_in = op; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin lat[i] = 0; zr[i] = 1'bx; end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && lat[i] == 0) begin lat[i] = c; zr[i] = zo[i]; end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_in = '0; op_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        total++; if (rdy[0] !== 1'b0)  $display("FAIL rst_inready: got %b want 0", rdy[0]);  else passed++;
        total++; if (ov[0] !== 1'b0)   $display("FAIL rst_outvalid: got %b want 0", ov[0]);  else passed++;
        total++; if (busy[0] !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy[0]);    else passed++;
        total++; if (zo[0] !== 1'b0)   $display("FAIL rst_z: got %b want 0", zo[0]);         else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (rdy !== 3'b111) $display("FAIL rel_inready: got %b want 111", rdy); else passed++;
    endtask

    task automatic test_and();
        run_op(32'hFFFF_FFFF, 2'b00);
        total++; if (zr[0] !== 1'b1) $display("FAIL and_ones_z: got %b want 1", zr[0]);      else passed++;
        total++; if (lat[0] !== 5)   $display("FAIL and_ones_lat: got %0d want 5", lat[0]);  else passed++;
        total++; if (zr[2] !== 1'b1) $display("FAIL and_w10_ones_z: got %b want 1", zr[2]);  else passed++;
        run_op(32'hFFFF_00FF, 2'b00);
        total++; if (zr[0] !== 1'b0) $display("FAIL and_early_z: got %b want 0", zr[0]);     else passed++;
        total++; if (lat[0] !== 3)   $display("FAIL and_early_lat: got %0d want 3", lat[0]); else passed++;
        total++; if (zr[1] !== 1'b0) $display("FAIL and_noearly_z: got %b want 0", zr[1]);   else passed++;
        total++; if (lat[1] !== 5)   $display("FAIL and_noearly_lat: got %0d want 5", lat[1]); else passed++;
        run_op(32'hFFFF_FFFF, 2'b11);
        total++; if (zr[0] !== 1'b1) $display("FAIL rsv_ones_z: got %b want 1", zr[0]);      else passed++;
        run_op(32'h0000_0000, 2'b11);
        total++; if (lat[0] !== 2)   $display("FAIL rsv_zero_lat: got %0d want 2", lat[0]);  else passed++;
    endtask

    task automatic test_or();
        run_op(32'h0000_0000, 2'b01);
        total++; if (zr[0] !== 1'b0) $display("FAIL or_zero_z: got %b want 0", zr[0]);       else passed++;
        total++; if (lat[0] !== 5)   $display("FAIL or_zero_lat: got %0d want 5", lat[0]);   else passed++;
        run_op(32'h0000_0100, 2'b01);
        total++; if (zr[0] !== 1'b1) $display("FAIL or_early_z: got %b want 1", zr[0]);      else passed++;
        total++; if (lat[0] !== 3)   $display("FAIL or_early_lat: got %0d want 3", lat[0]);  else passed++;
        total++; if (lat[1] !== 5)   $display("FAIL or_noearly_lat: got %0d want 5", lat[1]); else passed++;
    endtask

    task automatic test_xor();
        run_op(32'h0000_0007, 2'b10);
        total++; if (zr[0] !== 1'b1) $display("FAIL xor7_z: got %b want 1", zr[0]);          else passed++;
        total++; if (lat[0] !== 5)   $display("FAIL xor7_lat: got %0d want 5", lat[0]);      else passed++;
        run_op(32'h8000_0001, 2'b10);
        total++; if (zr[0] !== 1'b0) $display("FAIL xor_msb_lsb_z: got %b want 0", zr[0]);   else passed++;
        total++; if (zr[1] !== 1'b0) $display("FAIL xor_ne_z: got %b want 0", zr[1]);        else passed++;
    endtask

    task automatic test_w10();
        run_op(32'h0000_0200, 2'b01);
        total++; if (zr[2] !== 1'b1) $display("FAIL w10_or_z: got %b want 1", zr[2]);        else passed++;
        total++; if (lat[2] !== 4)   $display("FAIL w10_or_lat: got %0d want 4", lat[2]);    else passed++;
        run_op(32'h0000_03FF, 2'b00);
        total++; if (zr[2] !== 1'b1) $display("FAIL w10_and_pad_z: got %b want 1", zr[2]);   else passed++;
        total++; if (lat[2] !== 4)   $display("FAIL w10_and_lat: got %0d want 4", lat[2]);   else passed++;
        run_op(32'h0000_0300, 2'b10);
        total++; if (zr[2] !== 1'b0) $display("FAIL w10_xor_z: got %b want 0", zr[2]);       else passed++;
    endtask

    task automatic test_backpressure();
        int c;
        @(negedge clk);
        a_in = 32'hFFFF_FFFF; op_in = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        c = 0;
        while (!ov[0] && c < 20) begin @(negedge clk); c++; end
        total++; if (c !== 5) $display("FAIL bp_lat: got %0d want 5", c); else passed++;
        for (int i = 0; i < 3; i++) begin
            a_in = (i % 2 == 0) ? 32'h0 : 32'h5555_5555; op_in = 2'b01; in_valid = 1'b1;
            @(negedge clk);
            total++; if (ov[0] !== 1'b1)  $display("FAIL bp_hold_ov[%0d]: got %b want 1", i, ov[0]);  else passed++;
            total++; if (zo[0] !== 1'b1)  $display("FAIL bp_hold_z[%0d]: got %b want 1", i, zo[0]);   else passed++;
            total++; if (rdy[0] !== 1'b0) $display("FAIL bp_hold_rdy[%0d]: got %b want 0", i, rdy[0]); else passed++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (ov[0] !== 1'b0)  $display("FAIL bp_release_ov: got %b want 0", ov[0]);  else passed++;
        total++; if (rdy[0] !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", rdy[0]); else passed++;
        run_op(32'h0000_0000, 2'b00);
        total++; if (zr[0] !== 1'b0) $display("FAIL bp_next_z: got %b want 0", zr[0]);      else passed++;
        total++; if (lat[0] !== 2)   $display("FAIL bp_next_lat: got %0d want 2", lat[0]);  else passed++;
    endtask

    task automatic test_reset_midrun();
        bit seen;
        @(negedge clk);
        a_in = 32'hFFFF_FFFF; op_in = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2;
        total++; if (busy[0] !== 1'b1) $display("FAIL mid_busy_pre: got %b want 1", busy[0]); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (ov[0] !== 1'b0)   $display("FAIL mid_rst_ov: got %b want 0", ov[0]);     else passed++;
        total++; if (busy[0] !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy[0]); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (rdy[0] !== 1'b1) $display("FAIL mid_rel_rdy: got %b want 1", rdy[0]); else passed++;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL mid_no_output: got %b want 0", seen); else passed++;
        run_op(32'h0000_0000, 2'b00);
        total++; if (zr[0] !== 1'b0) $display("FAIL mid_next_z: got %b want 0", zr[0]);     else passed++;
        total++; if (lat[0] !== 2)   $display("FAIL mid_next_lat: got %0d want 2", lat[0]); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_and();
        test_or();
        test_xor();
        test_w10();
        test_backpressure();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
